wb_arb2: RTL

- Two-master, one-slave Wishbone (pipelined, with stall) arbiter. It lets the CPU cluster and a second bus master (debug/DMA) share a single slave path, such as the RAM port behind the interconnect.
- Grant is held for an entire bus cycle (cyc high) and is handed off round-robin.
- It counts outstanding requests so that ack/err are returned to the owning master, and it throttles a master that reaches the outstanding limit.

---
 rtl/wb_arb2.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wb_arb2.sv
// ---------------------------------------------------------------------------
// wb_arb2 -- two-master, one-slave Wishbone (pipelined, with stall) arbiter.
//
// Lets the CPU cluster (master 0) and a second bus master such as debug/DMA
// (master 1) share one slave path. A grant is held for a whole bus cycle
// (cyc high). At cycle boundaries ownership is handed round-robin. The number
// of accepted-but-unacknowledged requests is tracked so the owner is
// throttled once it reaches MAX_OUTST.
//
// Ports
//   clk, rst_n            single clock; asynchronous active-low reset
//   mN_wb_*_o  (inputs)   request from master N (addr, dat, sel, cyc, stb, we)
//   mN_wb_*_i  (outputs)  response to master N (dat, stall, ack, err)
//   s_wb_*_o   (outputs)  request to the slave
//   s_wb_*_i   (inputs)   response from the slave (dat, stall, ack, err)
//   grant_o               one-hot current owner {G1, G0}, registered
// ---------------------------------------------------------------------------
module wb_arb2 #(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [AWIDTH-1:0]   m0_wb_addr_o,
  input  logic [DWIDTH-1:0]   m0_wb_dat_o,
  input  logic [DWIDTH/8-1:0] m0_wb_sel_o,
  input  logic                m0_wb_cyc_o,
  input  logic                m0_wb_stb_o,
  input  logic                m0_wb_we_o,
  output logic [DWIDTH-1:0]   m0_wb_dat_i,
  output logic                m0_wb_stall_i,
  output logic                m0_wb_ack_i,
  output logic                m0_wb_err_i,

  input  logic [AWIDTH-1:0]   m1_wb_addr_o,
  input  logic [DWIDTH-1:0]   m1_wb_dat_o,
  input  logic [DWIDTH/8-1:0] m1_wb_sel_o,
  input  logic                m1_wb_cyc_o,
  input  logic                m1_wb_stb_o,
  input  logic                m1_wb_we_o,
  output logic [DWIDTH-1:0]   m1_wb_dat_i,
  output logic                m1_wb_stall_i,
  output logic                m1_wb_ack_i,
  output logic                m1_wb_err_i,

  output logic [AWIDTH-1:0]   s_wb_addr_o,
  output logic [DWIDTH-1:0]   s_wb_dat_o,
  output logic [DWIDTH/8-1:0] s_wb_sel_o,
  output logic                s_wb_cyc_o,
  output logic                s_wb_stb_o,
  output logic                s_wb_we_o,
  input  logic [DWIDTH-1:0]   s_wb_dat_i,
  input  logic                s_wb_stall_i,
  input  logic                s_wb_ack_i,
  input  logic                s_wb_err_i,

  output logic [1:0]          grant_o
);

  // State encoding doubles as the one-hot grant vector {G1, G0}.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_G0   = 2'b01;
  localparam logic [1:0] ST_G1   = 2'b10;

  localparam logic [3:0] LIMIT = 4'(MAX_OUTST);

  logic [1:0] r_state;
  logic [3:0] r_outst;
  logic       r_last;

  logic       w_at_limit;
  logic       w_accept;
  logic       w_resp;
  logic [3:0] w_outst_nxt;

  assign grant_o    = r_state;
  assign w_at_limit = (r_outst == LIMIT);

  // Slave-side request mux and master-side response demux.
  always_comb begin
    s_wb_addr_o   = '0;
    s_wb_dat_o    = '0;
    s_wb_sel_o    = '0;
    s_wb_cyc_o    = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_we_o     = 1'b0;
    m0_wb_dat_i   = '0;
    m0_wb_stall_i = 1'b1;
    m0_wb_ack_i   = 1'b0;
    m0_wb_err_i   = 1'b0;
    m1_wb_dat_i   = '0;
    m1_wb_stall_i = 1'b1;
    m1_wb_ack_i   = 1'b0;
    m1_wb_err_i   = 1'b0;
    case (r_state)
      ST_G0: begin
        s_wb_addr_o   = m0_wb_addr_o;
        s_wb_dat_o    = m0_wb_dat_o;
        s_wb_sel_o    = m0_wb_sel_o;
        s_wb_we_o     = m0_wb_we_o;
        s_wb_cyc_o    = m0_wb_cyc_o;
        // At the outstanding limit the strobe is held back and the master
        // stalled, so nothing can be accepted until a response drains one.
        s_wb_stb_o    = m0_wb_stb_o & ~w_at_limit;
        m0_wb_stall_i = s_wb_stall_i | w_at_limit;
        m0_wb_dat_i   = s_wb_dat_i;
        m0_wb_ack_i   = s_wb_ack_i;
        m0_wb_err_i   = s_wb_err_i;
      end
      ST_G1: begin
        s_wb_addr_o   = m1_wb_addr_o;
        s_wb_dat_o    = m1_wb_dat_o;
        s_wb_sel_o    = m1_wb_sel_o;
        s_wb_we_o     = m1_wb_we_o;
        s_wb_cyc_o    = m1_wb_cyc_o;
        s_wb_stb_o    = m1_wb_stb_o & ~w_at_limit;
        m1_wb_stall_i = s_wb_stall_i | w_at_limit;
        m1_wb_dat_i   = s_wb_dat_i;
        m1_wb_ack_i   = s_wb_ack_i;
        m1_wb_err_i   = s_wb_err_i;
      end
      default: begin
      end
    endcase
  end

  assign w_accept = s_wb_stb_o & ~s_wb_stall_i;
  assign w_resp   = s_wb_ack_i | s_wb_err_i;

  // Outstanding count; a stray response at zero is forwarded but not counted.
  always_comb begin
    w_outst_nxt = r_outst;
    case ({w_accept, w_resp})
      2'b10:   w_outst_nxt = r_outst + 4'd1;
      2'b01:   w_outst_nxt = (r_outst == 4'd0) ? 4'd0 : r_outst - 4'd1;
      default: w_outst_nxt = r_outst;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_outst <= 4'd0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_outst <= 4'd0;
          if (m0_wb_cyc_o && m1_wb_cyc_o)
            r_state <= r_last ? ST_G0 : ST_G1;
          else if (m0_wb_cyc_o)
            r_state <= ST_G0;
          else if (m1_wb_cyc_o)
            r_state <= ST_G1;
        end
        ST_G0: begin
          if (!m0_wb_cyc_o) begin
            // Cycle ended or aborted: anything still in flight is dropped.
            r_outst <= 4'd0;
            r_last  <= 1'b0;
            r_state <= m1_wb_cyc_o ? ST_G1 : ST_IDLE;
          end else begin
            r_outst <= w_outst_nxt;
          end
        end
        ST_G1: begin
          if (!m1_wb_cyc_o) begin
            r_outst <= 4'd0;
            r_last  <= 1'b1;
            r_state <= m0_wb_cyc_o ? ST_G0 : ST_IDLE;
          end else begin
            r_outst <= w_outst_nxt;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_outst <= 4'd0;
        end
      endcase
    end
  end

endmodule
